// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: load-op encoding, FSM states, control payload.
package mem_pkg;

    localparam int unsigned LD_OP_W = 3;
    localparam int unsigned REG_W   = 5;

    typedef enum logic [LD_OP_W-1:0] {
        LD_B  = 3'd0,
        LD_H  = 3'd1,
        LD_W  = 3'd2,
        LD_D  = 3'd3,
        LD_BU = 3'd4,
        LD_HU = 3'd5,
        LD_WU = 3'd6
    } ld_op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } mem_state_e;

    // Control fields latched with each instruction entering MEM
    typedef struct packed {
        logic [LD_OP_W-1:0] ld_op;
        logic               res_from_mem;
        logic               gr_we;
        logic [REG_W-1:0]   dest;
    } mem_ctrl_t;

    // Only 32- and 64-bit datapaths are supported
    function automatic bit data_w_legal(input int unsigned w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/mem_stage_rsp_ld_extend.sv
// Load data extraction: selects the byte lane by address and sign/zero extends.
module ld_extend
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]             rdata,
    input  logic [$clog2(DATA_W/8)-1:0]   addr_lo,
    input  logic [LD_OP_W-1:0]            ld_op,
    output logic [DATA_W-1:0]             ext_data
);

    logic [DATA_W-1:0] lane;

    // Little-endian lane alignment: addressed byte moves to bit 0
    assign lane = rdata >> {addr_lo, 3'b000};

    // Extension by access size and signedness
    always_comb begin
        ext_data = '0;
        case (ld_op)
            LD_B:    ext_data = DATA_W'($signed(lane[7:0]));
            LD_BU:   ext_data = DATA_W'(lane[7:0]);
            LD_H:    ext_data = DATA_W'($signed(lane[15:0]));
            LD_HU:   ext_data = DATA_W'(lane[15:0]);
            LD_W:    ext_data = DATA_W'($signed(lane[31:0]));
            LD_WU:   ext_data = DATA_W'(lane[31:0]);
            LD_D:    ext_data = (DATA_W == 64) ? lane : 'x;
            default: ext_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_rsp.sv
// MEM pipeline stage that waits for an SRAM data response, holds it across WB
// stalls, extends loads and discards responses belonging to flushed loads.
// Optional build macro: MEM_LD_PERF_EN adds perf_ld_wait_cnt.
module mem_stage_rsp
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned PC_W            = 32,
    parameter int unsigned MAX_OUTSTANDING = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exe_to_mem_valid,
    output logic               mem_allow_in,
    input  logic [DATA_W-1:0]  exe_alu_result,
    input  logic [2:0]         exe_ld_op,
    input  logic               exe_res_from_mem,
    input  logic               exe_gr_we,
    input  logic [4:0]         exe_dest,
    input  logic [PC_W-1:0]    exe_pc,
    input  logic               flush,
    input  logic               data_sram_data_ok,
    input  logic [DATA_W-1:0]  data_sram_rdata,
    output logic               mem_to_wb_valid,
    input  logic               wb_allow_in,
    output logic [DATA_W-1:0]  mem_wb_result,
    output logic               mem_wb_gr_we,
    output logic [4:0]         mem_wb_dest,
    output logic [PC_W-1:0]    mem_wb_pc,
    output logic               mem_fwd_we,
    output logic [4:0]         mem_fwd_dest,
    output logic [DATA_W-1:0]  mem_fwd_data,
    output logic               mem_fwd_pending
`ifdef MEM_LD_PERF_EN
    ,
    output logic [31:0]        perf_ld_wait_cnt
`endif
);

    localparam int unsigned OFF_W  = $clog2(DATA_W/8);
    localparam int unsigned DROP_W = $clog2(MAX_OUTSTANDING + 1);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("mem_stage_rsp: DATA_W must be 32 or 64");
    end

    mem_state_e           state;
    logic [DROP_W-1:0]    drop_cnt;
    mem_ctrl_t            ctrl_q;
    logic [DATA_W-1:0]    alu_q;
    logic [DATA_W-1:0]    hold_q;
    logic [PC_W-1:0]      pc_q;
    logic [DATA_W-1:0]    ext_data;

    logic st_wait, st_ready, st_empty;
    logic drop_live, rsp_hit, drop_inc, drop_dec;
    logic out_valid, handoff, accept;

    ld_extend #(.DATA_W(DATA_W)) u_ld_extend (
        .rdata    (data_sram_rdata),
        .addr_lo  (alu_q[OFF_W-1:0]),
        .ld_op    (ctrl_q.ld_op),
        .ext_data (ext_data)
    );

    // Handshake and response classification
    always_comb begin
        st_wait   = (state == WAIT);
        st_ready  = (state == READY);
        st_empty  = (state == EMPTY);
        drop_live = (drop_cnt != '0);
        // A response belongs to the waiting load only once all stale ones are gone
        rsp_hit   = st_wait & data_sram_data_ok & ~drop_live;
        drop_dec  = data_sram_data_ok & drop_live;
        drop_inc  = flush & st_wait & ~rsp_hit;
        out_valid = ~flush & (st_ready | rsp_hit);
        handoff   = out_valid & wb_allow_in;
        accept    = exe_to_mem_valid & ~flush & (st_empty | handoff);
    end

    // Output decode; a response arriving while WB accepts bypasses the hold register
    always_comb begin
        mem_allow_in    = ~flush & (st_empty | handoff);
        mem_to_wb_valid = out_valid;
        mem_wb_result   = st_wait ? ext_data
                                  : (ctrl_q.res_from_mem ? hold_q : alu_q);
        mem_wb_gr_we    = ctrl_q.gr_we;
        mem_wb_dest     = ctrl_q.dest;
        mem_wb_pc       = pc_q;
        mem_fwd_we      = ctrl_q.gr_we & ~st_empty;
        mem_fwd_dest    = ctrl_q.dest;
        mem_fwd_data    = mem_wb_result;
        mem_fwd_pending = st_wait;
    end

    // FSM and stale-response counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_cnt + DROP_W'(drop_inc) - DROP_W'(drop_dec);
            if (flush)
                state <= EMPTY;
            else if (accept)
                state <= exe_res_from_mem ? WAIT : READY;
            else if (rsp_hit)
                state <= wb_allow_in ? EMPTY : READY;
            else if (st_ready & wb_allow_in)
                state <= EMPTY;
        end
    end

    // Datapath capture; contents are meaningful only while state is not EMPTY
    always_ff @(posedge clk) begin
        if (accept) begin
            ctrl_q <= '{ld_op: exe_ld_op, res_from_mem: exe_res_from_mem,
                        gr_we: exe_gr_we, dest: exe_dest};
            alu_q  <= exe_alu_result;
            pc_q   <= exe_pc;
        end
        if (rsp_hit)
            hold_q <= ext_data;
    end

`ifdef MEM_LD_PERF_EN
    // Saturating count of cycles spent waiting on load data
    always_ff @(posedge clk) begin
        if (reset)
            perf_ld_wait_cnt <= '0;
        else if (st_wait & ~data_sram_data_ok & (perf_ld_wait_cnt != '1))
            perf_ld_wait_cnt <= perf_ld_wait_cnt + 32'd1;
    end
`endif

    // More cancelled responses in flight than the counter can track
    a_drop_overflow: assert property (@(posedge clk) disable iff (reset)
        !(drop_inc && !drop_dec && (drop_cnt == DROP_W'(MAX_OUTSTANDING))))
        else $error("mem_stage_rsp: drop counter overflow");

endmodule

// File: tb/tb_mem_stage_rsp.sv
// Bench for mem_stage_rsp: 32-bit and 64-bit instances, table-driven load
// vectors plus hand sequences for stall, flush and reset corner cases.
module tb_mem_stage_rsp;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // 32-bit instance
    logic        a_valid, a_rfm, a_we, a_flush, a_dok, a_wba;
    logic [31:0] a_alu, a_rdata, a_pc;
    logic [2:0]  a_op;
    logic [4:0]  a_dest;
    logic        a_allow, a_ovalid, a_owe, a_fwe, a_pend;
    logic [31:0] a_res, a_opc, a_fdata;
    logic [4:0]  a_odest, a_fdest;
`ifdef MEM_LD_PERF_EN
    logic [31:0] a_perf, b_perf;
`endif

    // 64-bit instance
    logic        b_valid, b_rfm, b_we, b_flush, b_dok, b_wba;
    logic [63:0] b_alu, b_rdata, b_res, b_fdata;
    logic [31:0] b_pc, b_opc;
    logic [2:0]  b_op;
    logic [4:0]  b_dest, b_odest, b_fdest;
    logic        b_allow, b_ovalid, b_owe, b_fwe, b_pend;

    mem_stage_rsp #(.DATA_W(32), .PC_W(32), .MAX_OUTSTANDING(3)) u_dut32 (
        .clk(clk), .reset(reset),
`ifdef MEM_LD_PERF_EN
        .perf_ld_wait_cnt(a_perf),
`endif
        .exe_to_mem_valid(a_valid), .mem_allow_in(a_allow),
        .exe_alu_result(a_alu), .exe_ld_op(a_op), .exe_res_from_mem(a_rfm),
        .exe_gr_we(a_we), .exe_dest(a_dest), .exe_pc(a_pc), .flush(a_flush),
        .data_sram_data_ok(a_dok), .data_sram_rdata(a_rdata),
        .mem_to_wb_valid(a_ovalid), .wb_allow_in(a_wba), .mem_wb_result(a_res),
        .mem_wb_gr_we(a_owe), .mem_wb_dest(a_odest), .mem_wb_pc(a_opc),
        .mem_fwd_we(a_fwe), .mem_fwd_dest(a_fdest), .mem_fwd_data(a_fdata),
        .mem_fwd_pending(a_pend)
    );

    mem_stage_rsp #(.DATA_W(64), .PC_W(32), .MAX_OUTSTANDING(3)) u_dut64 (
        .clk(clk), .reset(reset),
`ifdef MEM_LD_PERF_EN
        .perf_ld_wait_cnt(b_perf),
`endif
        .exe_to_mem_valid(b_valid), .mem_allow_in(b_allow),
        .exe_alu_result(b_alu), .exe_ld_op(b_op), .exe_res_from_mem(b_rfm),
        .exe_gr_we(b_we), .exe_dest(b_dest), .exe_pc(b_pc), .flush(b_flush),
        .data_sram_data_ok(b_dok), .data_sram_rdata(b_rdata),
        .mem_to_wb_valid(b_ovalid), .wb_allow_in(b_wba), .mem_wb_result(b_res),
        .mem_wb_gr_we(b_owe), .mem_wb_dest(b_odest), .mem_wb_pc(b_opc),
        .mem_fwd_we(b_fwe), .mem_fwd_dest(b_fdest), .mem_fwd_data(b_fdata),
        .mem_fwd_pending(b_pend)
    );

    typedef struct {
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  dest;
        logic [31:0] pc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t tv_a[10];
    vec_t tv_b[7];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every WB handoff must match the oldest expected result
    task automatic mon();
        exp_t e;
        if (a_ovalid && a_wba) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected: got %0h want no result", a_res);
            end else begin
                e = q_a.pop_front();
                chk("a_result", 64'(a_res), e.data);
                chk("a_fwd_data", 64'(a_fdata), e.data);
                chk("a_dest", 64'(a_odest), 64'(e.dest));
                chk("a_pc", 64'(a_opc), 64'(e.pc));
            end
        end
        if (b_ovalid && b_wba) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: got %0h want no result", b_res);
            end else begin
                e = q_b.pop_front();
                chk("b_result", b_res, e.data);
                chk("b_dest", 64'(b_odest), 64'(e.dest));
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_valid = 0; a_rfm = 0; a_we = 0; a_flush = 0; a_dok = 0; a_wba = 1;
        a_alu = '0; a_rdata = '0; a_pc = '0; a_op = '0; a_dest = '0;
    endtask

    task automatic b_idle();
        b_valid = 0; b_rfm = 0; b_we = 0; b_flush = 0; b_dok = 0; b_wba = 1;
        b_alu = '0; b_rdata = '0; b_pc = '0; b_op = '0; b_dest = '0;
    endtask

    task automatic a_load(input logic [2:0] op, input logic [31:0] addr,
                          input logic [4:0] dest, input logic [31:0] pc);
        a_valid = 1; a_rfm = 1; a_we = 1; a_op = op; a_alu = addr;
        a_dest = dest; a_pc = pc;
    endtask

    task automatic a_push(input logic [63:0] d, input logic [4:0] dest, input logic [31:0] pc);
        exp_t e;
        e.data = d; e.dest = dest; e.pc = pc;
        q_a.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t eb;
        tv_a[0] = '{LD_B,  64'h1000_0003, 64'h80FF_0000, 64'hFFFF_FF80};
        tv_a[1] = '{LD_BU, 64'h1000_0003, 64'h80FF_0000, 64'h0000_0080};
        tv_a[2] = '{LD_B,  64'h1000_0001, 64'h1234_5678, 64'h0000_0056};
        tv_a[3] = '{LD_H,  64'h1000_0002, 64'h9ABC_1234, 64'hFFFF_9ABC};
        tv_a[4] = '{LD_HU, 64'h1000_0002, 64'h9ABC_1234, 64'h0000_9ABC};
        tv_a[5] = '{LD_H,  64'h1000_0000, 64'h9ABC_1234, 64'h0000_1234};
        tv_a[6] = '{LD_W,  64'h1000_0000, 64'hDEAD_BEEF, 64'hDEAD_BEEF};
        tv_a[7] = '{LD_WU, 64'h1000_0000, 64'h8000_0001, 64'h8000_0001};
        tv_a[8] = '{LD_B,  64'h1000_0000, 64'h0000_00FF, 64'hFFFF_FFFF};
        tv_a[9] = '{LD_BU, 64'h1000_0002, 64'h00AB_0000, 64'h0000_00AB};

        tv_b[0] = '{LD_W,  64'h2000_0004, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001};
        tv_b[1] = '{LD_WU, 64'h2000_0004, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001};
        tv_b[2] = '{LD_D,  64'h2000_0000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        tv_b[3] = '{LD_B,  64'h2000_0007, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        tv_b[4] = '{LD_HU, 64'h2000_0006, 64'hFEDC_0000_0000_0000, 64'h0000_0000_0000_FEDC};
        tv_b[5] = '{LD_W,  64'h2000_0000, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};
        tv_b[6] = '{LD_H,  64'h2000_0004, 64'h0000_8001_0000_0000, 64'hFFFF_FFFF_FFFF_8001};

        // Reset state
        reset = 1; a_idle(); b_idle();
        adv(); adv();
        cyc();
        chk("rst_a_valid", 64'(a_ovalid), 0);
        chk("rst_a_fwd_we", 64'(a_fwe), 0);
        chk("rst_a_pending", 64'(a_pend), 0);
        chk("rst_b_valid", 64'(b_ovalid), 0);
        adv();
        reset = 0;

        // Pipelined loads, data_ok the cycle after entry: one result per cycle
        for (int i = 0; i <= 10; i++) begin
            a_idle();
            if (i < 10) begin
                a_load(tv_a[i].op, tv_a[i].addr[31:0], 5'(i + 1), 32'h100 + 32'(4 * i));
                a_push(tv_a[i].exp, 5'(i + 1), 32'h100 + 32'(4 * i));
            end
            if (i > 0) begin
                a_dok = 1;
                a_rdata = tv_a[i - 1].rdata[31:0];
            end
            cyc();
            chk("pipe_allow", 64'(a_allow), 1);
            chk("pipe_pending", 64'(a_pend), 64'(i > 0));
            adv();
        end
        a_idle();
        cyc();
        chk("pipe_drain_valid", 64'(a_ovalid), 0);
        chk("pipe_drain_pending", 64'(a_pend), 0);
        adv();

        // WB stall after response: data held in READY
        a_idle(); a_wba = 0;
        a_load(LD_HU, 32'h1000_0002, 5'd7, 32'h200);
        a_push(64'h0000_9ABC, 5'd7, 32'h200);
        cyc(); adv();
        a_valid = 0; a_dok = 1; a_rdata = 32'h9ABC_1234;
        cyc();
        chk("stall_rsp_valid", 64'(a_ovalid), 1);
        adv();
        a_dok = 0; a_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("hold_valid", 64'(a_ovalid), 1);
            chk("hold_result", 64'(a_res), 64'h0000_9ABC);
            chk("hold_pending", 64'(a_pend), 0);
            chk("hold_allow", 64'(a_allow), 0);
            adv();
        end
        a_wba = 1;
        cyc();
        chk("hold_release_allow", 64'(a_allow), 1);
        adv();
        a_idle();
        cyc();
        chk("hold_after_valid", 64'(a_ovalid), 0);
        adv();

        // Flush in WAIT; stale response dropped while the next load waits
        a_load(LD_W, 32'h1000_0000, 5'd3, 32'h300);
        cyc(); adv();
        a_valid = 0; a_flush = 1;
        cyc();
        chk("flush_allow", 64'(a_allow), 0);
        chk("flush_valid", 64'(a_ovalid), 0);
        adv();
        a_flush = 0;
        a_load(LD_W, 32'h1000_0000, 5'd4, 32'h304);
        a_push(64'h2222_2222, 5'd4, 32'h304);
        cyc();
        chk("post_flush_allow", 64'(a_allow), 1);
        adv();
        a_valid = 0; a_dok = 1; a_rdata = 32'h1111_1111;
        cyc();
        chk("stale_valid", 64'(a_ovalid), 0);
        chk("stale_pending", 64'(a_pend), 1);
        adv();
        a_rdata = 32'h2222_2222;
        cyc();
        chk("fresh_valid", 64'(a_ovalid), 1);
        adv();
        a_idle();
        cyc();
        chk("fresh_after_pending", 64'(a_pend), 0);
        adv();

        // Flush and own response in the same cycle: nothing left to drop
        a_load(LD_B, 32'h1000_0000, 5'd5, 32'h400);
        cyc(); adv();
        a_valid = 0; a_flush = 1; a_dok = 1; a_rdata = 32'h0000_0055;
        cyc();
        chk("netzero_flush_valid", 64'(a_ovalid), 0);
        adv();
        a_idle();
        a_load(LD_BU, 32'h1000_0001, 5'd6, 32'h404);
        a_push(64'h0000_007F, 5'd6, 32'h404);
        cyc(); adv();
        a_valid = 0; a_dok = 1; a_rdata = 32'h0000_7F00;
        cyc();
        chk("netzero_valid", 64'(a_ovalid), 1);
        adv();
        a_idle();

        // Back-to-back ALU results
        for (int i = 0; i < 6; i++) begin
            a_idle();
            a_valid = 1; a_we = 1; a_op = LD_W; a_alu = 32'hA000_0000 + 32'(i * 'h111);
            a_dest = 5'(10 + i); a_pc = 32'h500 + 32'(4 * i);
            a_push(64'(32'hA000_0000 + 32'(i * 'h111)), 5'(10 + i), 32'h500 + 32'(4 * i));
            cyc();
            chk("alu_allow", 64'(a_allow), 1);
            chk("alu_pending", 64'(a_pend), 0);
            chk("alu_valid", 64'(a_ovalid), 64'(i > 0));
            adv();
        end
        a_idle();
        cyc();
        chk("alu_last_valid", 64'(a_ovalid), 1);
        adv();
        cyc();
        chk("alu_drain_valid", 64'(a_ovalid), 0);
        adv();

        // 64-bit datapath, pipelined
        for (int i = 0; i <= 7; i++) begin
            b_idle();
            if (i < 7) begin
                b_valid = 1; b_rfm = 1; b_we = 1; b_op = tv_b[i].op;
                b_alu = tv_b[i].addr; b_dest = 5'(i + 1); b_pc = 32'h600 + 32'(4 * i);
                eb.data = tv_b[i].exp; eb.dest = 5'(i + 1); eb.pc = 32'h600 + 32'(4 * i);
                q_b.push_back(eb);
            end
            if (i > 0) begin
                b_dok = 1;
                b_rdata = tv_b[i - 1].rdata;
            end
            cyc();
            chk("b_pipe_allow", 64'(b_allow), 1);
            adv();
        end
        b_idle();
        cyc();
        chk("b_drain_valid", 64'(b_ovalid), 0);
        adv();

        // Reset while WAIT with two stale responses outstanding
        for (int k = 0; k < 2; k++) begin
            a_load(LD_W, 32'h1000_0000, 5'd1, 32'h700);
            cyc(); adv();
            a_valid = 0; a_flush = 1;
            cyc(); adv();
            a_flush = 0;
        end
        a_load(LD_W, 32'h1000_0000, 5'd2, 32'h708);
        cyc(); adv();
        a_valid = 0;
        cyc();
        chk("pre_rst_pending", 64'(a_pend), 1);
        adv();
        reset = 1;
        cyc(); adv();
        reset = 0;
        cyc();
        chk("rst_wait_valid", 64'(a_ovalid), 0);
        chk("rst_wait_pending", 64'(a_pend), 0);
        chk("rst_wait_fwd_we", 64'(a_fwe), 0);
        chk("rst_wait_allow", 64'(a_allow), 1);
`ifdef MEM_LD_PERF_EN
        chk("rst_perf", 64'(a_perf), 0);
`endif
        adv();
        // Counter cleared: the first response is delivered, not dropped
        a_load(LD_W, 32'h1000_0000, 5'd9, 32'h800);
        a_push(64'hABCD_0123, 5'd9, 32'h800);
        cyc(); adv();
        a_valid = 0; a_dok = 1; a_rdata = 32'hABCD_0123;
        cyc();
        chk("rst_drop_cleared", 64'(a_ovalid), 1);
        adv();
        a_idle();
`ifdef MEM_LD_PERF_EN
        a_load(LD_W, 32'h1000_0000, 5'd8, 32'h900);
        a_push(64'h0000_1357, 5'd8, 32'h900);
        cyc(); adv();
        a_valid = 0;
        cyc(); adv();
        cyc(); adv();
        a_dok = 1; a_rdata = 32'h0000_1357;
        cyc();
        chk("perf_wait_cnt", 64'(a_perf), 2);
        adv();
        a_idle();
        cyc();
        chk("perf_wait_hold", 64'(a_perf), 2);
        adv();
`endif

        chk("q_a_empty", 64'(q_a.size()), 0);
        chk("q_b_empty", 64'(q_b.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_rsp.md
Name: mem_stage_rsp

Overview:
- Parametrised memory-access pipeline stage between EXE and WB.
- Unlike a fixed single-cycle MEM stage, it waits for an SRAM-style data response (`data_ok`).
- It buffers the load data when WB stalls, extends loads to the full width (byte, half, word and, when 64-bit, double), and discards stale responses after a flush.
- It drives a forwarding bus that also reports "load result still pending" so EXE/ID can stall dependents.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- PC_W, 32, PC width carried to WB.
- MAX_OUTSTANDING, 3, maximum number of cancelled responses still in flight; sets the drop-counter width to clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exe_to_mem_valid  in  1  EXE holds a valid instruction
- mem_allow_in  out  1  MEM accepts this cycle
- exe_alu_result  in  DATA_W  address or ALU result
- exe_ld_op  in  3  load type (package encoding)
- exe_res_from_mem  in  1  instruction issued a data request and needs the response
- exe_gr_we  in  1  register write enable
- exe_dest  in  5  destination register
- exe_pc  in  PC_W  instruction PC
- flush  in  1  cancel the instruction held in MEM
- data_sram_data_ok  in  1  response valid
- data_sram_rdata  in  DATA_W  response data
- mem_to_wb_valid  out  1  result valid toward WB
- wb_allow_in  in  1  WB accepts
- mem_wb_result  out  DATA_W  final result
- mem_wb_gr_we  out  1  write enable to WB
- mem_wb_dest  out  5  destination to WB
- mem_wb_pc  out  PC_W  PC to WB
- mem_fwd_we  out  1  gr_we & valid, for the forwarding network
- mem_fwd_dest  out  5  forwarded destination
- mem_fwd_data  out  DATA_W  forwarded data (meaningful only when not pending)
- mem_fwd_pending  out  1  load in MEM whose data has not arrived yet

Behaviour:
- Reset: state=EMPTY; drop_cnt=0; mem_to_wb_valid=0; mem_fwd_we=0; mem_fwd_pending=0. Datapath registers are don't-care.
- States:
  - EMPTY
  - WAIT: load waiting for data_ok
  - READY: result available, WB not yet taken
- Acceptance: mem_allow_in = ~flush & (state==EMPTY | mem_to_wb_valid & wb_allow_in). On exe_to_mem_valid & mem_allow_in, fields are latched and the next state is WAIT if exe_res_from_mem, else READY.
- data_ok in WAIT with drop_cnt==0:
  - if wb_allow_in: the extended rdata goes to WB combinationally in the same cycle (mem_to_wb_valid=1).
  - else: the extended data is captured in a hold register and the state becomes READY.
- In READY, mem_wb_result comes from the hold register, or from the ALU result for non-loads.
- data_ok with drop_cnt>0 decrements drop_cnt and is ignored. This takes priority over delivery to the current WAIT instruction.
- Flush:
  - Next state is EMPTY and no instruction is accepted that cycle.
  - If the state was WAIT, drop_cnt increments, unless data_ok for that instruction arrives in the same cycle (net zero).
  - Incrementing drop_cnt when it equals MAX_OUTSTANDING is a protocol error; simulation asserts.
- Load extension by exe_alu_result low bits (byte lane, little endian):
  - LD_B/LD_BU: sign/zero extend from bit 7.
  - LD_H/LD_HU: sign/zero extend from bit 15.
  - LD_W/LD_WU: sign/zero extend from bit 31; at DATA_W=32 both pass the word through.
  - LD_D: whole word; legal only when DATA_W=64, otherwise the result is X.
- Alignment faults are detected upstream; MEM ignores them.
- mem_fwd_pending = (state==WAIT). mem_fwd_data is the same value as mem_wb_result.
- Simultaneous WB handoff and new acceptance forms a pipeline bubble-free chain, giving 1 instruction/cycle throughput when data_ok arrives the cycle after entry.

Optional Feature:
- Macro MEM_LD_PERF_EN.
- When defined: adds output perf_ld_wait_cnt (32 bits), which increments each cycle state==WAIT & ~data_ok, saturates at 0xFFFFFFFF and is cleared by reset.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_pkg holds:
  - ld_op encoding: LD_B=0, LD_H=1, LD_W=2, LD_D=3, LD_BU=4, LD_HU=5, LD_WU=6
  - state enum: EMPTY/WAIT/READY
  - the DATA_W legality check function
- One combinational sub-module, ld_extend (DATA_W parameter; inputs rdata, addr low bits, ld_op; output extended data).

Test Plan:
1. DATA_W=32: ld.b at addr 0x...3, rdata=0x80FF_0000, data_ok the next cycle, wb_allow_in=1 -> result 0xFFFF_FF80 in that same cycle, state EMPTY after.
2. ld.hu at addr 0x...2, rdata=0x9ABC_1234, with wb_allow_in low 3 cycles after data_ok -> state READY, result 0x0000_9ABC held stable until WB accepts.
3. Load in WAIT, flush asserted, data_ok arrives 2 cycles later while a new load (rdata 0x1111_1111 expected 0x2222_2222) waits -> first response dropped, drop_cnt 1→0, new load receives 0x2222_2222.
4. Back-to-back ALU ops (res_from_mem=0) with wb_allow_in=1 -> one result per cycle, mem_fwd_pending=0 throughout.
5. DATA_W=64: ld.w at addr 0x...4, rdata=0x8000_0001_0000_0000 -> 0xFFFF_FFFF_8000_0001; ld.wu -> 0x0000_0000_8000_0001.
6. Reset asserted while in WAIT with drop_cnt=2 -> next cycle state EMPTY, drop_cnt 0, mem_to_wb_valid 0; under MEM_LD_PERF_EN, perf_ld_wait_cnt reads 0.
